// File: rtl/one_slot_break_r_pkg.sv
// Shared constants and helpers for the ready-path register slice.
// Holds the default payload width and the next-occupancy rule used by the control.
package one_slot_break_r_pkg;

    localparam int unsigned OSB_DEFAULT_W = 32;

    // The slot stays occupied whenever a valid token is offered downstream but not taken.
    function automatic logic osb_full_next(input logic outs_valid, input logic outs_ready);
        return outs_valid & ~outs_ready;
    endfunction

endpackage

// File: rtl/one_slot_break_r_dataless.sv
// Control half of the ready-path cut: the occupancy flop and the valid/ready logic.
// ins_ready comes straight from the flop, so outs_ready never reaches it combinationally.
module one_slot_break_r_dataless
    import one_slot_break_r_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ins_valid,
    output logic ins_ready,
    output logic outs_valid,
    input  logic outs_ready
);

    logic full_q;
    logic full_d;

    // Next occupancy: hold while the offered token is refused.
    always_comb begin
        full_d = osb_full_next(outs_valid, outs_ready);
    end

    // Occupancy flop; reset empties the slot without waiting for an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    assign ins_ready  = ~full_q;
    assign outs_valid = ins_valid | full_q;

endmodule

// File: rtl/one_slot_break_r.sv
// Single-slot skid buffer cutting the backward (ready) path of a valid/ready channel.
// Transparent while empty; a refused token is parked in the data register until drained.
module one_slot_break_r
    import one_slot_break_r_pkg::*;
#(
    parameter int unsigned DATA_TYPE = OSB_DEFAULT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    logic [DATA_TYPE-1:0] data_q;
    logic [DATA_TYPE-1:0] data_d;
    logic                 capture_s;

    one_slot_break_r_dataless u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    // Park the incoming token only when the slot is empty and downstream refuses it.
    always_comb begin
        capture_s = ins_valid & ins_ready & ~outs_ready;
        if (capture_s) begin
            data_d = ins;
        end else begin
            data_d = data_q;
        end
    end

    // Payload register, cleared asynchronously together with the occupancy flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= {DATA_TYPE{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    // ins_ready low means the slot is full, so the parked token takes precedence.
    always_comb begin
        if (ins_ready) begin
            outs = ins;
        end else begin
            outs = data_q;
        end
    end

endmodule

// File: tb/tb_one_slot_break_r.sv
// Self-checking bench for one_slot_break_r: directed scenarios plus randomized backpressure
// against a queue-based capacity-1 FIFO reference model and an in-order scoreboard.
module tb_one_slot_break_r;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ins = 32'd0;
    logic        ins_valid = 1'b0;
    logic        ins_ready;
    logic [31:0] outs;
    logic        outs_valid;
    logic        outs_ready = 1'b0;

    logic        b_ins = 1'b0;
    logic        b_ins_valid = 1'b0;
    logic        b_ins_ready;
    logic        b_outs;
    logic        b_outs_valid;
    logic        b_outs_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] held[$];
    logic [31:0] sb[$];
    int accepted = 0;
    int emitted = 0;

    always #5 clk = ~clk;

    one_slot_break_r #(.DATA_TYPE(32)) u_dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready)
    );

    one_slot_break_r #(.DATA_TYPE(1)) u_dut1 (
        .clk(clk), .rst(rst), .ins(b_ins), .ins_valid(b_ins_valid), .ins_ready(b_ins_ready),
        .outs(b_outs), .outs_valid(b_outs_valid), .outs_ready(b_outs_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, compare against the model, then advance through the clock edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input bit full_chk);
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_outs;
        logic        rdy_before;
        ins_valid = v; ins = d; outs_ready = r;
        #1;
        exp_ready = (held.size() == 0);
        exp_valid = v || (held.size() != 0);
        exp_outs  = (held.size() != 0) ? held[0] : d;
        if (full_chk) begin
            chk("ins_ready", {31'd0, ins_ready}, {31'd0, exp_ready});
            chk("outs_valid", {31'd0, outs_valid}, {31'd0, exp_valid});
            chk("outs", outs, exp_outs);
            rdy_before = ins_ready;
            outs_ready = ~r;
            #1;
            chk("ready_isolation", {31'd0, ins_ready}, {31'd0, rdy_before});
            outs_ready = r;
            #1;
        end
        if (v && exp_ready) begin
            sb.push_back(d);
            accepted++;
        end
        if (exp_valid && r) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk("sb_order", outs, sb.pop_front());
            end
            emitted++;
        end
        if (held.size() != 0) begin
            if (r) void'(held.pop_front());
        end else if (v && !r) begin
            held.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        // Reset values, observed without any clock edge.
        #2;
        chk("rst_ins_ready", {31'd0, ins_ready}, 32'd1);
        chk("rst_outs_valid", {31'd0, outs_valid}, 32'd0);
        ins_valid = 1'b1; ins = 32'hCAFE0001;
        #1;
        chk("rst_outs_valid_pass", {31'd0, outs_valid}, 32'd1);
        chk("rst_outs_pass", outs, 32'hCAFE0001);
        ins_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1, 1'b1);

        // Pass-through: three tokens in three cycles.
        emitted = 0;
        cycle(1'b1, 32'h11, 1'b1, 1'b1);
        cycle(1'b1, 32'h22, 1'b1, 1'b1);
        cycle(1'b1, 32'h33, 1'b1, 1'b1);
        chk("pass_tokens", emitted, 32'd3);

        // Skid capture, ignored input while full, then drain.
        cycle(1'b1, 32'hA5, 1'b0, 1'b1);
        cycle(1'b1, 32'h5A, 1'b0, 1'b1);
        chk("skid_outs", outs, 32'hA5);
        cycle(1'b1, 32'h5A, 1'b1, 1'b1);
        chk("drain_ready", {31'd0, ins_ready}, 32'd1);
        chk("drain_transparent", outs, 32'h5A);
        cycle(1'b1, 32'h5A, 1'b1, 1'b1);

        // Randomized traffic: 70% valid, 50% ready.
        accepted = 0; emitted = 0; guard = 0;
        while (accepted < 1000 && guard < 20000) begin
            cycle(($urandom_range(99) < 70) ? 1'b1 : 1'b0, $urandom, $urandom_range(1) == 1, 1'b1);
            guard++;
        end
        chk("random_budget", (guard < 20000) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1);
        chk("random_no_loss", sb.size(), 32'd0);
        chk("random_count", emitted, accepted);

        // Reset while full: the held token is dropped with no clock edge.
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        ins_valid = 1'b0; outs_ready = 1'b0;
        #1;
        chk("full_outs", outs, 32'hDEADBEEF);
        chk("full_valid", {31'd0, outs_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ins_ready}, 32'd1);
        chk("midrst_valid", {31'd0, outs_valid}, 32'd0);
        ins_valid = 1'b1; ins = 32'h12345678;
        #1;
        chk("midrst_valid_track", {31'd0, outs_valid}, 32'd1);
        chk("midrst_outs", outs, 32'h12345678);
        held.delete(); sb.delete();
        ins_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Same scenario at one-bit width.
        b_ins_valid = 1'b1; b_ins = 1'b1; b_outs_ready = 1'b0;
        @(posedge clk); #1;
        b_ins = 1'b0;
        #1;
        chk("w1_full_ready", {31'd0, b_ins_ready}, 32'd0);
        chk("w1_full_outs", {31'd0, b_outs}, 32'd1);
        rst = 1'b0;
        #1;
        chk("w1_midrst_ready", {31'd0, b_ins_ready}, 32'd1);
        chk("w1_midrst_valid", {31'd0, b_outs_valid}, {31'd0, b_ins_valid});
        chk("w1_midrst_outs", {31'd0, b_outs}, 32'd0);
        b_ins_valid = 1'b0;
        #1;
        chk("w1_midrst_novalid", {31'd0, b_outs_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("w1_after_rst", {31'd0, b_ins_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
